// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the sequence detector.
// Ports: clk, rst (sync active-low), din/din_valid/din_ready in, A/A_valid/A_last out.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             A,
  output logic             A_valid,
  output logic             A_last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;
  logic             obit;

  assign last      = (state == SHIFT) && (cnt == LAST);
  assign accept    = din_valid && din_ready;
  assign obit      = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

  assign A_valid   = (state == SHIFT);
  assign A_last    = last;
  assign din_ready = (state == IDLE) || last;
  assign A         = (state == SHIFT) && obit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      // a word on the last bit cycle chains in with no bubble
      state <= SHIFT;
      shreg <= din;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      if (last) begin
        state <= IDLE;
        shreg <= '0;
        cnt   <= '0;
      end else begin
        if (MSB_FIRST)
          shreg <= {shreg[WIDTH-2:0], 1'b0};
        else
          shreg <= {1'b0, shreg[WIDTH-1:1]};
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed bench with a queue-based bit-stream model.
// Checks both bit orders every cycle plus literal expectations per scenario.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din0, din1;
  logic       dv0, dv1;
  logic       rdy0, a0, av0, al0;
  logic       rdy1, a1, av1, al1;

  int nc = 0;
  int nm = 0;
  bit chk = 1'b0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(dv0),
    .din_ready(rdy0), .A(a0), .A_valid(av0), .A_last(al0)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(dv1),
    .din_ready(rdy1), .A(a1), .A_valid(av1), .A_last(al1)
  );

  // model: queue of bits still to be shown on A, front = current bit
  bit q0[$];
  bit q1[$];

  always @(posedge clk) begin
    if (!rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (dv0 && q0.size() <= 1) begin
        q0.delete();
        for (int i = 7; i >= 0; i--) q0.push_back(din0[i]);
      end else if (q0.size() > 0) begin
        void'(q0.pop_front());
      end
      if (dv1 && q1.size() <= 1) begin
        q1.delete();
        for (int i = 0; i < 8; i++) q1.push_back(din1[i]);
      end else if (q1.size() > 0) begin
        void'(q1.pop_front());
      end
    end
  end

  task automatic cmp(input string nm_s, input logic [63:0] act,
                     input logic [63:0] exp);
    nc++;
    if (act !== exp) begin
      nm++;
      $display("FAIL %s: got %0h expected %0h", nm_s, act, exp);
    end
  endtask

  // capture of the valid bit stream seen by the detector
  logic [63:0] cap0, cap1;
  int ncap0, ncap1, runs0, nlast0, nlast1, nrdyv0;
  int cyc, first0, last0;
  bit pv0, lastbit1;

  task automatic clr();
    cap0 = '0; cap1 = '0;
    ncap0 = 0; ncap1 = 0; runs0 = 0;
    nlast0 = 0; nlast1 = 0; nrdyv0 = 0;
    first0 = -1; last0 = -1; pv0 = 1'b0;
    lastbit1 = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (chk) begin
      cmp("u0_A", 64'(a0), 64'(q0.size() > 0 ? q0[0] : 1'b0));
      cmp("u0_A_valid", 64'(av0), 64'(q0.size() > 0));
      cmp("u0_A_last", 64'(al0), 64'(q0.size() == 1));
      cmp("u0_din_ready", 64'(rdy0), 64'(q0.size() <= 1));
      cmp("u1_A", 64'(a1), 64'(q1.size() > 0 ? q1[0] : 1'b0));
      cmp("u1_A_valid", 64'(av1), 64'(q1.size() > 0));
      cmp("u1_A_last", 64'(al1), 64'(q1.size() == 1));
      cmp("u1_din_ready", 64'(rdy1), 64'(q1.size() <= 1));
    end
    if (av0) begin
      cap0 = {cap0[62:0], a0};
      ncap0++;
      if (!pv0) runs0++;
      if (first0 < 0) first0 = cyc;
      last0 = cyc;
      if (al0) nlast0++;
      if (rdy0) nrdyv0++;
    end
    pv0 = av0;
    if (av1) begin
      cap1 = {cap1[62:0], a1};
      ncap1++;
      if (al1) begin
        nlast1++;
        lastbit1 = a1;
      end
    end
  end

  function automatic int count01(input logic [63:0] c, input int n);
    int k = 0;
    for (int i = 0; i + 1 < n; i++)
      if (!c[i+1] && c[i]) k++;
    return k;
  endfunction

  task automatic send(input bit which, input logic [7:0] w);
    int t = 0;
    @(negedge clk);
    if (!which) begin
      din0 = w; dv0 = 1'b1;
    end else begin
      din1 = w; dv1 = 1'b1;
    end
    while (!(which ? rdy1 : rdy0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      nc++; nm++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk);
  endtask

  initial begin
    cyc = 0;
    clr();
    // 1: reset with din_valid high must not load
    rst = 1'b0; din0 = 8'hFF; dv0 = 1'b1; din1 = 8'hFF; dv1 = 1'b1;
    @(posedge clk);
    chk = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; dv0 = 1'b0; dv1 = 1'b0;
    cmp("rst_ready", 64'(rdy0), 64'd1);
    cmp("rst_A", 64'(a0), 64'd0);
    cmp("rst_A_valid", 64'(av0), 64'd0);
    cmp("rst_A_last", 64'(al0), 64'd0);

    // 2: single word 0x53
    @(posedge clk); clr();
    send(1'b0, 8'h53);
    @(negedge clk); dv0 = 1'b0;
    repeat (10) @(negedge clk);
    cmp("t2_bits", cap0, 64'h53);
    cmp("t2_nvalid", 64'(ncap0), 64'd8);
    cmp("t2_nlast", 64'(nlast0), 64'd1);
    cmp("t2_det01", 64'(count01(cap0, ncap0)), 64'd3);
    cmp("t2_idle_ready", 64'(rdy0), 64'd1);

    // 3: back-to-back 0xA5, 0x0F
    @(posedge clk); clr();
    send(1'b0, 8'hA5);
    send(1'b0, 8'h0F);
    @(negedge clk); dv0 = 1'b0;
    repeat (10) @(negedge clk);
    cmp("t3_bits", cap0, 64'hA50F);
    cmp("t3_nvalid", 64'(ncap0), 64'd16);
    cmp("t3_runs", 64'(runs0), 64'd1);
    cmp("t3_ready_in_word", 64'(nrdyv0), 64'd2);

    // 4: stall of three idle cycles between words
    @(posedge clk); clr();
    send(1'b0, 8'hFF);
    @(negedge clk); dv0 = 1'b0;
    repeat (9) @(negedge clk);
    send(1'b0, 8'h00);
    @(negedge clk); dv0 = 1'b0;
    repeat (10) @(negedge clk);
    cmp("t4_bits", cap0, 64'hFF00);
    cmp("t4_runs", 64'(runs0), 64'd2);
    cmp("t4_span", 64'(last0 - first0 + 1), 64'd19);

    // 5: reset after three bits of 0xFF
    @(posedge clk); clr();
    send(1'b0, 8'hFF);
    @(negedge clk); dv0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp("t5_A_valid", 64'(av0), 64'd0);
    cmp("t5_A", 64'(a0), 64'd0);
    cmp("t5_ready", 64'(rdy0), 64'd1);
    rst = 1'b1;
    send(1'b0, 8'h01);
    @(negedge clk); dv0 = 1'b0;
    repeat (10) @(negedge clk);
    cmp("t5_nvalid", 64'(ncap0), 64'd11);
    cmp("t5_bits", cap0, 64'b111_0000_0001);

    // 6: LSB-first instance, 0x80
    @(posedge clk); clr();
    send(1'b1, 8'h80);
    @(negedge clk); dv1 = 1'b0;
    repeat (10) @(negedge clk);
    cmp("t6_bits", cap1, 64'h01);
    cmp("t6_nvalid", 64'(ncap1), 64'd8);
    cmp("t6_nlast", 64'(nlast1), 64'd1);
    cmp("t6_lastbit", 64'(lastbit1), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nm);
    $finish;
  end

endmodule
